// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the Y86-64 SEQ datapath: owns the architectural PC
// and status register and steps six one-hot stage enables per instruction.
module seq_stage_controller #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             hlt,
    input  logic             invalid_instruction,
    input  logic             invalid_instruction_address,
    input  logic             invalid_data_address,
    input  logic [63:0]      new_pc,
    output logic [63:0]      pc,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pcupd_en,
    output logic [1:0]       status,
    output logic             running,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] active_cycles
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC   = 4'd3,
        ST_MEM    = 4'd4,
        ST_WB     = 4'd5,
        ST_PCUPD  = 4'd6,
        ST_PAUSE  = 4'd7,
        ST_HALTED = 4'd8
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    state_t           state_r;
    state_t           state_next_s;
    logic [1:0]       status_r;
    logic [1:0]       status_next_s;
    logic [63:0]      pc_r;
    logic [CNT_W-1:0] retired_r;
    logic [CNT_W-1:0] active_r;
    logic             active_s;

    assign pc            = pc_r;
    assign status        = status_r;
    assign retired       = retired_r;
    assign active_cycles = active_r;
    assign active_s      = (state_r >= ST_FETCH) && (state_r <= ST_PCUPD);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and next-status selection; clear overrides every transition.
    always_comb begin
        state_next_s  = state_r;
        status_next_s = status_r;
        if (clear) begin
            state_next_s  = ST_IDLE;
            status_next_s = STAT_AOK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (hlt) begin
                        state_next_s  = ST_HALTED;
                        status_next_s = STAT_HLT;
                    end else if (invalid_instruction_address) begin
                        state_next_s  = ST_HALTED;
                        status_next_s = STAT_ADR;
                    end else if (invalid_instruction) begin
                        state_next_s  = ST_HALTED;
                        status_next_s = STAT_INS;
                    end else begin
                        state_next_s = ST_DECODE;
                    end
                end
                ST_DECODE: state_next_s = ST_EXEC;
                ST_EXEC:   state_next_s = ST_MEM;
                ST_MEM: begin
                    // A data fault halts before WB so the register file stays untouched.
                    if (invalid_data_address) begin
                        state_next_s  = ST_HALTED;
                        status_next_s = STAT_ADR;
                    end else begin
                        state_next_s = ST_WB;
                    end
                end
                ST_WB: state_next_s = ST_PCUPD;
                ST_PCUPD: begin
                    if (step_mode) begin
                        state_next_s = ST_PAUSE;
                    end else begin
                        state_next_s = ST_FETCH;
                    end
                end
                ST_PAUSE: begin
                    if (step_req || !step_mode) begin
                        state_next_s = ST_FETCH;
                    end else begin
                        state_next_s = ST_PAUSE;
                    end
                end
                ST_HALTED: state_next_s = ST_HALTED;
                default: begin
                    state_next_s  = ST_IDLE;
                    status_next_s = STAT_AOK;
                end
            endcase
        end
    end

    // Architectural PC, status and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            status_r  <= STAT_AOK;
            retired_r <= '0;
            active_r  <= '0;
        end else if (clear) begin
            pc_r      <= RESET_PC;
            status_r  <= STAT_AOK;
            retired_r <= '0;
            active_r  <= '0;
        end else begin
            status_r <= status_next_s;
            if (state_r == ST_PCUPD) begin
                pc_r      <= new_pc;
                retired_r <= retired_r + CNT_W'(1);
            end
            if (active_s) begin
                active_r <= active_r + CNT_W'(1);
            end
        end
    end

    // Moore decode of the stage enables from the state register.
    always_comb begin
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        pcupd_en  = 1'b0;
        running   = active_s;
        case (state_r)
            ST_FETCH:  fetch_en  = 1'b1;
            ST_DECODE: decode_en = 1'b1;
            ST_EXEC:   exec_en   = 1'b1;
            ST_MEM:    mem_en    = 1'b1;
            ST_WB:     wb_en     = 1'b1;
            ST_PCUPD:  pcupd_en  = 1'b1;
            default: begin
                fetch_en = 1'b0;
            end
        endcase
    end

endmodule
